// File: rtl/seq_tx_pkg.sv
// Shared state type and default sizing for the serial pattern transmitter.
package seq_tx_pkg;

  localparam int   W_DEF        = 8;
  localparam int   LENW_DEF     = 4;
  localparam int   REPW_DEF     = 4;
  localparam int   GAP_DEF      = 2;
  localparam logic IDLE_BIT_DEF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/seq_tx_shreg.sv
// Frame shift register: presents the head bit (index len-1) of either the value
// being loaded this cycle or the stored value, and shifts left once it is consumed.
module seq_tx_shreg #(
  parameter int W    = 8,
  parameter int LENW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [W-1:0]    din,
  input  logic [LENW-1:0] len,
  output logic            bit_o
);

  logic [W-1:0]    sr_q, sr_d;
  logic [W-1:0]    src;
  logic [LENW-1:0] idx;

  always_comb begin
    src   = load ? din : sr_q;
    idx   = len - 1'b1;
    bit_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (idx == LENW'(i)) bit_o = src[i];
    end
    // The head bit leaves on the same edge that stores the register, so keep it pre-shifted.
    sr_d = sr_q;
    if (load) begin
      sr_d = din << 1;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured frame MSB-first, repeats it with
// an idle gap between copies, then pulses done. All outputs are registered.
//
// state    | meaning
// ST_IDLE  | waiting for start; len checked on start
// ST_SHIFT | driving a frame bit on dout every cycle
// ST_GAP   | idle cycles between repeated frames, still busy
// ST_DONE  | one-cycle done pulse; a new start is accepted here too
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   W        = W_DEF,
  parameter int   LENW     = LENW_DEF,
  parameter int   REPW     = REPW_DEF,
  parameter int   GAP      = GAP_DEF,
  parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [W-1:0]    pattern,
  input  logic [LENW-1:0] len,
  input  logic [REPW-1:0] reps,
  output logic            dout,
  output logic            dvalid,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int              GAPW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'((GAP > 0) ? GAP - 1 : 0);

  tx_state_e       state_q, state_d;
  logic [LENW-1:0] bit_cnt_q, bit_cnt_d;
  logic [REPW-1:0] frm_cnt_q, frm_cnt_d;
  logic [GAPW-1:0] gap_cnt_q, gap_cnt_d;
  logic [W-1:0]    pat_q, pat_d;
  logic [LENW-1:0] len_q, len_d;
  logic            dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            sh_load, sh_shift, sh_bit;
  logic [W-1:0]    sh_din;
  logic [LENW-1:0] sh_len;
  logic            len_ok;

  seq_tx_shreg #(
    .W    (W),
    .LENW (LENW)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .len   (sh_len),
    .bit_o (sh_bit)
  );

  assign len_ok = (len != '0) && (len <= LENW'(W));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frm_cnt_d = frm_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    dout_d    = IDLE_BIT;
    dvalid_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_din    = pat_q;
    sh_len    = len_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (len_ok) begin
            pat_d     = pattern;
            len_d     = len;
            frm_cnt_d = reps;
            bit_cnt_d = len - 1'b1;
            sh_load   = 1'b1;
            sh_din    = pattern;
            sh_len    = len;
            dout_d    = sh_bit;
            dvalid_d  = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_cnt_q != '0) begin
          sh_shift  = 1'b1;
          dout_d    = sh_bit;
          dvalid_d  = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else if (frm_cnt_q != '0) begin
          frm_cnt_d = frm_cnt_q - 1'b1;
          busy_d    = 1'b1;
          if (GAP > 0) begin
            gap_cnt_d = GAP_LAST;
            state_d   = ST_GAP;
          end else begin
            sh_load   = 1'b1;
            dout_d    = sh_bit;
            dvalid_d  = 1'b1;
            bit_cnt_d = len_q - 1'b1;
          end
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          busy_d    = 1'b1;
        end else begin
          sh_load   = 1'b1;
          dout_d    = sh_bit;
          dvalid_d  = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = len_q - 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      frm_cnt_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      dout_q    <= IDLE_BIT;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed scenarios plus randomized transfers
// compared cycle by cycle against an expected output stream built from the frame rules.
module tb_seq_pattern_tx;

  localparam int W      = 8;
  localparam int LENW   = 4;
  localparam int REPW   = 4;
  localparam int TB_GAP = 2;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [W-1:0]    pattern;
  logic [LENW-1:0] len;
  logic [REPW-1:0] reps;
  logic            dout, dvalid, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  // expected {dout, dvalid, busy, done, err} per cycle after the start edge
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .W        (W),
    .LENW     (LENW),
    .REPW     (REPW),
    .GAP      (TB_GAP),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .dout    (dout),
    .dvalid  (dvalid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  function automatic logic [4:0] obs();
    return {dout, dvalid, busy, done, err};
  endfunction

  // (reps+1) frames of len bits MSB-first, TB_GAP idle-but-busy cycles between, then done
  function automatic void add_transfer(input logic [W-1:0] p, input int l, input int r);
    for (int f = 0; f <= r; f++) begin
      for (int b = l - 1; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0, 1'b0});
      if (f < r) begin
        for (int g = 0; g < TB_GAP; g++) exp_q.push_back(5'b00100);
      end
    end
    exp_q.push_back(5'b00010);
  endfunction

  task automatic send_and_check(input string name, input logic [W-1:0] p, input int l,
                                input int r, input bit noise);
    logic [4:0] e, o;
    exp_q.delete();
    add_transfer(p, l, r);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    start = 1'b1; abort = 1'b0; pattern = p; len = LENW'(l); reps = REPW'(r);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      e = exp_q[k];
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s cycle %0d: dout/dvalid/busy/done/err got %b want %b", name, k, o, e);
      end
      @(negedge clk);
      if (noise && e[2]) begin
        start   = 1'($urandom);
        pattern = W'($urandom);
        len     = LENW'($urandom);
        reps    = REPW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
        n_bad++;
        $display("FAIL reset cycle %0d: outputs got %b want 00000", i, obs());
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_release: outputs got %b want 00000", obs());
    end
  endtask

  task automatic test_err();
    int bad_lens[3] = '{0, 9, 15};
    foreach (bad_lens[i]) begin
      @(negedge clk);
      start = 1'b1; len = LENW'(bad_lens[i]); pattern = W'($urandom); reps = 4'd1;
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== 5'b00001) begin
        n_bad++;
        $display("FAIL err_len%0d: outputs got %b want 00001", bad_lens[i], obs());
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
        n_bad++;
        $display("FAIL err_clear_len%0d: outputs got %b want 00000", bad_lens[i], obs());
      end
    end
  endtask

  typedef struct packed {
    logic            s;
    logic            a;
    logic [W-1:0]    p;
    logic [LENW-1:0] l;
    logic [REPW-1:0] r;
    logic [4:0]      e;
  } step_t;

  task automatic test_abort();
    step_t tbl[12] = '{
      '{1'b1, 1'b0, 8'hA5, 4'd8, 4'd0, 5'b11100},
      '{1'b0, 1'b0, 8'hA5, 4'd8, 4'd0, 5'b01100},
      '{1'b1, 1'b0, 8'h00, 4'd3, 4'd0, 5'b11100},
      '{1'b0, 1'b1, 8'h00, 4'd3, 4'd0, 5'b00000},
      '{1'b0, 1'b1, 8'h00, 4'd3, 4'd0, 5'b00000},
      '{1'b1, 1'b1, 8'h06, 4'd3, 4'd1, 5'b11100},
      '{1'b0, 1'b0, 8'h06, 4'd3, 4'd1, 5'b11100},
      '{1'b0, 1'b0, 8'h06, 4'd3, 4'd1, 5'b01100},
      '{1'b0, 1'b0, 8'h06, 4'd3, 4'd1, 5'b00100},
      '{1'b0, 1'b1, 8'h06, 4'd3, 4'd1, 5'b00000},
      '{1'b0, 1'b0, 8'h06, 4'd3, 4'd1, 5'b00000},
      '{1'b0, 1'b0, 8'h06, 4'd3, 4'd1, 5'b00000}
    };
    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].s; abort = tbl[i].a; pattern = tbl[i].p; len = tbl[i].l; reps = tbl[i].r;
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== tbl[i].e) begin
        n_bad++;
        $display("FAIL abort step %0d: outputs got %b want %b", i, obs(), tbl[i].e);
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] e, o;
    bit         second_sent = 1'b0;
    exp_q.delete();
    add_transfer(8'h0B, 4, 0);
    add_transfer(8'h5A, 3, 1);
    exp_q.push_back(5'b00000);
    @(negedge clk);
    start = 1'b1; abort = 1'b0; pattern = 8'h0B; len = 4'd4; reps = 4'd0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      e = exp_q[k];
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: outputs got %b want %b", k, o, e);
      end
      @(negedge clk);
      if (e[1] && !second_sent) begin
        start = 1'b1; pattern = 8'h5A; len = 4'd3; reps = 4'd1;
        second_sent = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      send_and_check("random", W'($urandom), int'($urandom_range(1, W)),
                     int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    pattern = 8'hFF; len = 4'd4; reps = 4'd0;
    test_reset();
    send_and_check("single_0b", 8'h0B, 4, 0, 1'b0);
    send_and_check("reps2_0b", 8'h0B, 4, 2, 1'b1);
    test_err();
    test_abort();
    test_back_to_back();
    send_and_check("reps_max", 8'h01, 1, 15, 1'b1);
    send_and_check("len_max", 8'hC3, 8, 1, 1'b1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
